// File: rtl/victim_cache.sv
// Fully associative victim cache behind an L1 d-cache: probes answer one cycle after acceptance, evicts fill or replace FIFO-wise.
// Backpressure: evicts stall only when they would displace a dirty line into an occupied write-back buffer; probes stall on a pending write-back of the same line.
module victim_cache #(
    parameter int ENTRIES = 4,
    parameter int LINE_W  = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lookup_valid_i,
    input  logic [31:0]       lookup_addr_i,
    output logic              lookup_ready_o,
    input  logic              evict_valid_i,
    input  logic [31:0]       evict_addr_i,
    input  logic [LINE_W-1:0] evict_data_i,
    input  logic              evict_dirty_i,
    output logic              evict_ready_o,
    output logic              swap_valid_o,
    output logic [LINE_W-1:0] swap_data_o,
    output logic              swap_dirty_o,
    output logic              vc_miss_o,
    output logic              wb_valid_o,
    output logic [31:0]       wb_addr_o,
    output logic [LINE_W-1:0] wb_data_o,
    input  logic              wb_ready_i,
    output logic [31:0]       no_hit_o,
    output logic [31:0]       no_miss_o
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] line_vld;
    logic [ENTRIES-1:0] line_dirty;
    logic [27:0]        line_tag  [ENTRIES];
    logic [LINE_W-1:0]  line_dat  [ENTRIES];
    logic [IDX_W-1:0]   fifo_ptr;

    logic               wb_vld;
    logic [31:0]        wb_addr;
    logic [LINE_W-1:0]  wb_dat;
    logic               swap_vld;
    logic               swap_dirty;
    logic [LINE_W-1:0]  swap_dat;
    logic               miss_vld;
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;

    logic [27:0]        lookup_tag;
    logic [27:0]        evict_tag;
    logic               lookup_hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               evict_match;
    logic [IDX_W-1:0]   match_idx;
    logic               has_free;
    logic [IDX_W-1:0]   free_idx;
    logic               lookup_fire;
    logic               evict_fire;
    logic               swap_in;
    logic               displace;
    logic               displace_dirty;
    logic [IDX_W-1:0]   write_idx;
    logic               write_dirty;
    logic               unused_addr_bits;

    assign lookup_tag       = lookup_addr_i[31:4];
    assign evict_tag        = evict_addr_i[31:4];
    assign unused_addr_bits = ^{lookup_addr_i[3:0], evict_addr_i[3:0]};

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        lookup_hit  = 1'b0;
        hit_idx     = '0;
        evict_match = 1'b0;
        match_idx   = '0;
        has_free    = 1'b0;
        free_idx    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (line_vld[i] && line_tag[i] == lookup_tag) begin
                lookup_hit = 1'b1;
                hit_idx    = IDX_W'(i);
            end
            if (line_vld[i] && line_tag[i] == evict_tag) begin
                evict_match = 1'b1;
                match_idx   = IDX_W'(i);
            end
            if (!line_vld[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign lookup_ready_o = !(wb_vld && wb_addr[31:4] == lookup_tag);
    assign lookup_fire    = lookup_valid_i && lookup_ready_o;
    // A hit slot freed in the same cycle takes the incoming evict directly.
    assign swap_in        = lookup_fire && lookup_hit && evict_valid_i;
    assign displace       = evict_valid_i && !swap_in && !evict_match && !has_free;
    assign displace_dirty = displace && line_dirty[fifo_ptr];
    assign evict_ready_o  = !(wb_vld && displace_dirty);
    assign evict_fire     = evict_valid_i && evict_ready_o;

    always_comb begin
        write_idx   = fifo_ptr;
        write_dirty = evict_dirty_i;
        if (swap_in) begin
            write_idx = hit_idx;
        end else if (evict_match) begin
            write_idx   = match_idx;
            write_dirty = line_dirty[match_idx] | evict_dirty_i;
        end else if (has_free) begin
            write_idx = free_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_vld   <= '0;
            line_dirty <= '0;
            fifo_ptr   <= '0;
            wb_vld     <= 1'b0;
            wb_addr    <= '0;
            wb_dat     <= '0;
            swap_vld   <= 1'b0;
            swap_dirty <= 1'b0;
            miss_vld   <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            swap_vld <= lookup_fire && lookup_hit;
            miss_vld <= lookup_fire && !lookup_hit;
            if (lookup_fire && lookup_hit) begin
                swap_dirty        <= line_dirty[hit_idx];
                line_vld[hit_idx] <= 1'b0;
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end
            if (lookup_fire && !lookup_hit && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (evict_fire) begin
                line_vld[write_idx]   <= 1'b1;
                line_dirty[write_idx] <= write_dirty;
                if (displace) fifo_ptr <= fifo_ptr + IDX_W'(1);
            end
            if (evict_fire && displace_dirty) begin
                wb_vld  <= 1'b1;
                wb_addr <= {line_tag[fifo_ptr], 4'h0};
                wb_dat  <= line_dat[fifo_ptr];
            end else if (wb_ready_i) begin
                wb_vld <= 1'b0;
            end
        end
    end

    // Payload storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (evict_fire) begin
            line_tag[write_idx] <= evict_tag;
            line_dat[write_idx] <= evict_data_i;
        end
        if (lookup_fire && lookup_hit) begin
            swap_dat <= line_dat[hit_idx];
        end
    end

    assign swap_valid_o = swap_vld;
    assign swap_data_o  = swap_dat;
    assign swap_dirty_o = swap_dirty;
    assign vc_miss_o    = miss_vld;
    assign wb_valid_o   = wb_vld;
    assign wb_addr_o    = wb_addr;
    assign wb_data_o    = wb_dat;
    assign no_hit_o     = hit_cnt;
    assign no_miss_o    = miss_cnt;
endmodule

// File: tb/tb_victim_cache.sv
// Scoreboarded bench for victim_cache: directed probes/evicts queue expected responses, a monitor compares them.
module tb_victim_cache;
    localparam int LW = 128;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          lookup_valid_i = 1'b0;
    logic [31:0]   lookup_addr_i = '0;
    logic          lookup_ready_o;
    logic          evict_valid_i = 1'b0;
    logic [31:0]   evict_addr_i = '0;
    logic [LW-1:0] evict_data_i = '0;
    logic          evict_dirty_i = 1'b0;
    logic          evict_ready_o;
    logic          swap_valid_o;
    logic [LW-1:0] swap_data_o;
    logic          swap_dirty_o;
    logic          vc_miss_o;
    logic          wb_valid_o;
    logic [31:0]   wb_addr_o;
    logic [LW-1:0] wb_data_o;
    logic          wb_ready_i = 1'b0;
    logic [31:0]   no_hit_o;
    logic [31:0]   no_miss_o;

    victim_cache #(.ENTRIES(4), .LINE_W(LW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i), .lookup_ready_o(lookup_ready_o),
        .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
        .evict_dirty_i(evict_dirty_i), .evict_ready_o(evict_ready_o),
        .swap_valid_o(swap_valid_o), .swap_data_o(swap_data_o), .swap_dirty_o(swap_dirty_o),
        .vc_miss_o(vc_miss_o),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i),
        .no_hit_o(no_hit_o), .no_miss_o(no_miss_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic hit; logic [LW-1:0] data; logic dirty; } resp_t;
    typedef struct packed { logic [31:0] addr; logic [LW-1:0] data; } wb_t;

    resp_t rq[$];
    wb_t   wq[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_hits = 0;
    int    exp_misses = 0;

    function automatic logic [LW-1:0] mkd(input logic [31:0] x);
        return {x, ~x, x ^ 32'h5A5A_5A5A, x + 32'd1};
    endfunction

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_resp(input logic hit, input logic [LW-1:0] data, input logic dirty);
        rq.push_back({hit, data, dirty});
        if (hit) exp_hits++;
        else exp_misses++;
    endtask

    // Drive one transaction at the falling edge, hold until accepted on a rising edge.
    task automatic cycle(input logic lv, input logic [31:0] la, input logic ev,
                         input logic [31:0] ea, input logic [LW-1:0] ed, input logic edy);
        int n;
        n = 0;
        @(negedge clk_i);
        lookup_valid_i = lv;
        lookup_addr_i  = la;
        evict_valid_i  = ev;
        evict_addr_i   = ea;
        evict_data_i   = ed;
        evict_dirty_i  = edy;
        #1;
        while (((lv && !lookup_ready_o) || (ev && !evict_ready_o)) && n < 50) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: lookup_ready=%0b evict_ready=%0b required 1", lookup_ready_o, evict_ready_o);
        end
        @(posedge clk_i);
        #1;
        lookup_valid_i = 1'b0;
        evict_valid_i  = 1'b0;
    endtask

    initial begin
        resp_t e;
        wb_t   w;
        forever begin
            @(negedge clk_i);
            #3;
            if (rst_ni) begin
                if (swap_valid_o && vc_miss_o) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_both: swap=1 miss=1 required exactly one");
                end else if (swap_valid_o || vc_miss_o) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: swap=%0b miss=%0b required none", swap_valid_o, vc_miss_o);
                    end else begin
                        e = rq.pop_front();
                        chk_b("resp_is_hit", swap_valid_o, e.hit);
                        if (e.hit) begin
                            chk_d("swap_data", swap_data_o, e.data);
                            chk_b("swap_dirty", swap_dirty_o, e.dirty);
                        end
                    end
                end
                if (wb_valid_o && wb_ready_i) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected: addr %0h required no write-back", wb_addr_o);
                    end else begin
                        w = wq.pop_front();
                        chk_w("wb_addr", wb_addr_o, w.addr);
                        chk_d("wb_data", wb_data_o, w.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk_b("rst_lookup_ready", lookup_ready_o, 1'b1);
        chk_b("rst_evict_ready", evict_ready_o, 1'b1);
        chk_b("rst_swap_valid", swap_valid_o, 1'b0);
        chk_b("rst_vc_miss", vc_miss_o, 1'b0);
        chk_b("rst_wb_valid", wb_valid_o, 1'b0);
        chk_w("rst_no_hit", no_hit_o, 32'd0);
        chk_w("rst_no_miss", no_miss_o, 32'd0);
        #10;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Probe on empty cache
        push_resp(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h2000, 1'b0, 32'h0, '0, 1'b0);
        chk_w("miss_cnt_empty", no_miss_o, exp_misses);
        chk_w("hit_cnt_empty", no_hit_o, exp_hits);

        // Clean evict then hit, then re-probe misses
        cycle(1'b0, 32'h0, 1'b1, 32'h1000, mkd(32'h1000), 1'b0);
        push_resp(1'b1, mkd(32'h1000), 1'b0);
        cycle(1'b1, 32'h1004, 1'b0, 32'h0, '0, 1'b0);
        chk_w("hit_cnt_first", no_hit_o, exp_hits);
        push_resp(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h1000, 1'b0, 32'h0, '0, 1'b0);
        chk_w("miss_cnt_reprobe", no_miss_o, exp_misses);

        // Fill with dirty lines, then displace slot 0
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 32'h100 * i, mkd(32'h100 * i), 1'b1);
        end
        wq.push_back({32'h100, mkd(32'h100)});
        cycle(1'b0, 32'h0, 1'b1, 32'h500, mkd(32'h500), 1'b1);
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk_b("wb_hold_valid", wb_valid_o, 1'b1);
            chk_w("wb_hold_addr", wb_addr_o, 32'h100);
        end

        // Second dirty displacement blocked behind the pending write-back
        @(negedge clk_i);
        evict_valid_i = 1'b1;
        evict_addr_i  = 32'h600;
        evict_data_i  = mkd(32'h600);
        evict_dirty_i = 1'b1;
        #1;
        chk_b("evict_blocked_0", evict_ready_o, 1'b0);
        @(negedge clk_i);
        #1;
        chk_b("evict_blocked_1", evict_ready_o, 1'b0);
        @(negedge clk_i);
        wb_ready_i = 1'b1;
        #1;
        chk_b("evict_blocked_hs", evict_ready_o, 1'b0);
        wq.push_back({32'h200, mkd(32'h200)});
        @(posedge clk_i);
        #1;
        wb_ready_i = 1'b0;
        chk_b("evict_unblocked", evict_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        evict_valid_i = 1'b0;
        @(negedge clk_i);
        lookup_addr_i = 32'h208;
        #1;
        chk_b("wb2_valid", wb_valid_o, 1'b1);
        chk_w("wb2_addr", wb_addr_o, 32'h200);
        chk_b("lookup_blocked", lookup_ready_o, 1'b0);
        lookup_addr_i = 32'h300;
        #1;
        chk_b("lookup_other_line", lookup_ready_o, 1'b1);
        @(negedge clk_i);
        wb_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        wb_ready_i = 1'b0;
        chk_b("wb_drained", wb_valid_o, 1'b0);

        // Probe hit on slot 2 with a simultaneous evict: swap, pointer stays at 2
        push_resp(1'b1, mkd(32'h300), 1'b1);
        cycle(1'b1, 32'h300, 1'b1, 32'h900, mkd(32'h900), 1'b0);
        @(negedge clk_i);
        #1;
        chk_b("swap_no_wb", wb_valid_o, 1'b0);
        // In-place update keeps the dirty bit
        cycle(1'b0, 32'h0, 1'b1, 32'h500, mkd(32'h5B), 1'b0);
        // Displaces the clean 0x900 line at pointer 2
        cycle(1'b0, 32'h0, 1'b1, 32'hA00, mkd(32'hA00), 1'b0);
        @(negedge clk_i);
        #1;
        chk_b("clean_drop_no_wb", wb_valid_o, 1'b0);
        push_resp(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h900, 1'b0, 32'h0, '0, 1'b0);
        push_resp(1'b1, mkd(32'h400), 1'b1);
        cycle(1'b1, 32'h400, 1'b0, 32'h0, '0, 1'b0);
        push_resp(1'b1, mkd(32'h5B), 1'b1);
        cycle(1'b1, 32'h500, 1'b0, 32'h0, '0, 1'b0);
        chk_w("hit_cnt_mid", no_hit_o, exp_hits);
        chk_w("miss_cnt_mid", no_miss_o, exp_misses);

        // Lowest free slots refilled, then slot 3 (0xC00) displaced
        cycle(1'b0, 32'h0, 1'b1, 32'hB00, mkd(32'hB00), 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'hC00, mkd(32'hC00), 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'hD00, mkd(32'hD00), 1'b0);
        @(negedge clk_i);
        #1;
        chk_b("wb3_valid", wb_valid_o, 1'b1);
        chk_w("wb3_addr", wb_addr_o, 32'hC00);
        chk_d("wb3_data", wb_data_o, mkd(32'hC00));

        // Asynchronous reset while the write-back is pending
        #1;
        rst_ni = 1'b0;
        #1;
        chk_b("arst_wb_valid", wb_valid_o, 1'b0);
        chk_b("arst_swap_valid", swap_valid_o, 1'b0);
        chk_b("arst_vc_miss", vc_miss_o, 1'b0);
        chk_w("arst_no_hit", no_hit_o, 32'd0);
        chk_w("arst_no_miss", no_miss_o, 32'd0);
        chk_b("arst_evict_ready", evict_ready_o, 1'b1);
        chk_b("arst_lookup_ready", lookup_ready_o, 1'b1);
        wq.delete();
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        push_resp(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h600, 1'b0, 32'h0, '0, 1'b0);
        chk_w("post_rst_miss_cnt", no_miss_o, exp_misses);
        chk_w("post_rst_hit_cnt", no_hit_o, exp_hits);

        repeat (2) @(negedge clk_i);
        #4;
        chk_w("resp_queue_drained", rq.size(), 32'd0);
        chk_w("wb_queue_drained", wq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
